// File: rtl/mcpu_bus_pkg.sv
// Shared types and constants for the MCPU shared data-bus arbiter.
package mcpu_bus_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned N_REQ      = 3;
    localparam int unsigned MAX_BURST  = 8;
    localparam int unsigned IDX_W      = $clog2(N_REQ);
    localparam int unsigned CNT_W      = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        REG_DRAM = 2'b00,
        REG_VRAM = 2'b01,
        REG_IROM = 2'b10,
        REG_NONE = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic dram_re;
        logic dram_we;
        logic vram_re;
        logic vram_we;
        logic irom_re;
    } strobe_t;

    function automatic region_e addr_region(input logic [DATA_WIDTH-1:0] addr);
        return region_e'(addr[DATA_WIDTH-1 -: 2]);
    endfunction

    // All-zero result marks a protected or unmapped access.
    function automatic strobe_t decode_strobe(input logic [DATA_WIDTH-1:0] addr,
                                              input logic                  we);
        strobe_t s;
        s = '0;
        case (addr_region(addr))
            REG_DRAM: begin
                s.dram_we = we;
                s.dram_re = !we;
            end
            REG_VRAM: begin
                s.vram_we = we;
                s.vram_re = !we;
            end
            REG_IROM: s.irom_re = !we;
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mcpu_bus_arbiter_if.sv
// Requester and memory-side signals of the shared MCPU data bus.
interface mcpu_bus_arbiter_if;
    import mcpu_bus_pkg::*;

    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*DATA_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]       rdata;
    logic [DATA_WIDTH-1:0]       bus_addr;
    logic [DATA_WIDTH-1:0]       bus_wdata;
    logic [DATA_WIDTH-1:0]       bus_din;
    logic                        dram_re;
    logic                        dram_we;
    logic                        vram_re;
    logic                        vram_we;
    logic                        irom_re;
    logic                        err;

    // Requesters plus the memory read-data source.
    modport master (
        output req, req_we, req_addr, req_wdata, bus_din,
        input  gnt, ack, rdata, bus_addr, bus_wdata,
        input  dram_re, dram_we, vram_re, vram_we, irom_re, err
    );

    // The arbiter.
    modport slave (
        input  req, req_we, req_addr, req_wdata, bus_din,
        output gnt, ack, rdata, bus_addr, bus_wdata,
        output dram_re, dram_we, vram_re, vram_we, irom_re, err
    );

endinterface

// File: rtl/mcpu_rr_pick.sv
// Combinational winner select: requester 0 has fixed priority, the rest
// rotate starting at rr_ptr and wrapping from N_REQ-1 back to 1.
module mcpu_rr_pick
    import mcpu_bus_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IDX_W-1:0] win_idx_o
);

    localparam int unsigned N_RR = N_REQ - 1;

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    logic             found;

    assign base = (rr_ptr_i == '0) ? '0 : rr_ptr_i - IDX_W'(1);

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        if (req_i[0]) begin
            win_o[0] = 1'b1;
            found    = 1'b1;
        end else begin
            for (int unsigned k = 0; k < N_RR; k++) begin
                cand = IDX_W'(((32'(base) + k) % N_RR) + 32'd1);
                if (!found && req_i[cand]) begin
                    win_o[cand] = 1'b1;
                    win_idx_o   = cand;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mcpu_bus_arbiter.sv
// Shared data-bus sequencer: grants one master per access, decodes the
// DRAM/VRAM/IROM strobes and returns registered read data with a one-cycle ack.
module mcpu_bus_arbiter
    import mcpu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mcpu_bus_arbiter_if.slave bus
);

    state_e                state_q,     state_d;
    logic [IDX_W-1:0]      winner_q,    winner_d;
    logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [N_REQ-1:0]      gnt_q,       gnt_d;
    logic [N_REQ-1:0]      ack_q,       ack_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic [DATA_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    strobe_t               strobe_q,    strobe_d;
    logic                  bad_q,       bad_d;
    logic                  we_q,        we_d;
    logic                  err_q,       err_d;

    logic [N_REQ-1:0]      pick_win;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    strobe_t               sel_strobe;
    logic [CNT_W-1:0]      burst_inc;
    logic                  gpu_preempt;
    logic                  burst_more;
    logic                  load_access;

    mcpu_rr_pick u_pick (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_ptr_q),
        .win_o     (pick_win),
        .win_idx_o (pick_idx)
    );

    // Operands of the access about to enter ACCESS: a fresh winner from IDLE,
    // or the current winner when a burst continues from DONE.
    always_comb begin
        sel_idx   = (state_q == IDLE) ? pick_idx : winner_q;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_addr  = bus.req_addr[k*DATA_WIDTH +: DATA_WIDTH];
                sel_wdata = bus.req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = bus.req_we[k];
            end
        end
        sel_strobe = decode_strobe(sel_addr, sel_we);
    end

    assign burst_inc   = burst_cnt_q + CNT_W'(1);
    assign gpu_preempt = (winner_q != '0) && bus.req[0];
    assign burst_more  = bus.req[winner_q] && (burst_inc < CNT_W'(MAX_BURST)) && !gpu_preempt;

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        burst_cnt_d = burst_cnt_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strobe_d    = '0;
        bad_d       = bad_q;
        we_d        = we_q;
        err_d       = err_q;
        load_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    winner_d    = pick_idx;
                    gnt_d       = pick_win;
                    burst_cnt_d = '0;
                    load_access = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                ack_d   = gnt_q;
                rdata_d = (!we_q && !bad_q) ? bus.bus_din : '0;
                err_d   = err_q | bad_q;
                state_d = DONE;
            end
            DONE: begin
                burst_cnt_d = burst_inc;
                if (burst_more) begin
                    load_access = 1'b1;
                    state_d     = ACCESS;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    if (winner_q != '0) begin
                        rr_ptr_d = (winner_q == IDX_W'(N_REQ - 1)) ? IDX_W'(1)
                                                                   : winner_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus drive and strobes are registered so they are live exactly in ACCESS.
        if (load_access) begin
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
            we_d     = sel_we;
            strobe_d = sel_strobe;
            bad_d    = (sel_strobe == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            rr_ptr_q    <= IDX_W'(1);
            gnt_q       <= '0;
            ack_q       <= '0;
            burst_cnt_q <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strobe_q    <= '0;
            bad_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            burst_cnt_q <= burst_cnt_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strobe_q    <= strobe_d;
            bad_q       <= bad_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.dram_re   = strobe_q.dram_re;
    assign bus.dram_we   = strobe_q.dram_we;
    assign bus.vram_re   = strobe_q.vram_re;
    assign bus.vram_we   = strobe_q.vram_we;
    assign bus.irom_re   = strobe_q.irom_re;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mcpu_bus_arbiter.sv
// Directed bench for mcpu_bus_arbiter: timing, arbitration order, bursts,
// preemption, protection and reset behaviour against hand-computed values.
module tb_mcpu_bus_arbiter;
    import mcpu_bus_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mcpu_bus_arbiter_if bus_if ();

    mcpu_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int unsigned n_checks    = 0;
    int unsigned n_errors    = 0;
    int unsigned cycle_cnt   = 0;
    int unsigned onehot_viol = 0;
    int unsigned pending [N_REQ];
    int          ack_who [$];
    int unsigned ack_at  [$];
    int          exp_q   [$];
    logic        din_force_en;
    logic [15:0] din_force;

    // Memory model: forced value or an address-derived pattern.
    assign bus_if.bus_din = din_force_en ? din_force : (bus_if.bus_addr ^ 16'hA5A5);

    function automatic logic [4:0] strobes_now();
        return {bus_if.dram_re, bus_if.dram_we, bus_if.vram_re, bus_if.vram_we, bus_if.irom_re};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; each master keeps req high until its last queued access is in ACCESS.
    task automatic cyc();
        @(negedge clk);
        cycle_cnt++;
        if ($countones(bus_if.gnt) > 1 || $countones(strobes_now()) > 1) onehot_viol++;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (bus_if.ack[i]) begin
                ack_who.push_back(i);
                ack_at.push_back(cycle_cnt);
            end
            if (bus_if.gnt[i] && !bus_if.ack[i] && pending[i] != 0) pending[i]--;
            bus_if.req[i] = (pending[i] != 0);
        end
    endtask

    task automatic post(input int idx, input int unsigned n, input logic [15:0] addr,
                        input logic we, input logic [15:0] wd);
        pending[idx] = n;
        bus_if.req_addr[idx*16 +: 16]  = addr;
        bus_if.req_wdata[idx*16 +: 16] = wd;
        bus_if.req_we[idx]             = we;
        bus_if.req[idx]                = 1'b1;
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned t;
        int unsigned left;
        t = 0;
        left = 1;
        while (left != 0 && t < budget) begin
            cyc();
            t++;
            left = (bus_if.gnt != '0) ? 1 : 0;
            for (int i = 0; i < int'(N_REQ); i++) left += pending[i];
        end
        check({tag, "_drained"}, 32'(left == 0), 32'd1);
    endtask

    task automatic check_order(input string tag);
        check({tag, "_count"}, ack_who.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ack_who.size(); i++)
            check($sformatf("%s_ack%0d", tag, i), ack_who[i], exp_q[i]);
    endtask

    task automatic clear_log();
        ack_who.delete();
        ack_at.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        din_force_en     = 1'b0;
        din_force        = '0;
        bus_if.req       = '0;
        bus_if.req_we    = '0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        for (int i = 0; i < int'(N_REQ); i++) pending[i] = 0;

        repeat (3) cyc();
        check("rst_gnt",    bus_if.gnt,       0);
        check("rst_ack",    bus_if.ack,       0);
        check("rst_strobe", strobes_now(),    0);
        check("rst_addr",   bus_if.bus_addr,  0);
        check("rst_wdata",  bus_if.bus_wdata, 0);
        check("rst_rdata",  bus_if.rdata,     0);
        check("rst_err",    bus_if.err,       0);
        reset = 1'b0;
        cyc();

        // Single DRAM read, exact cycle timing.
        din_force_en = 1'b1;
        din_force    = 16'hBEEF;
        post(1, 1, 16'h0123, 1'b0, 16'h0000);
        cyc();
        check("rd_gnt",       bus_if.gnt,      3'b010);
        check("rd_dram_re",   strobes_now(),   5'b10000);
        check("rd_addr",      bus_if.bus_addr, 16'h0123);
        check("rd_no_ack",    bus_if.ack,      0);
        cyc();
        check("rd_ack",       bus_if.ack,      3'b010);
        check("rd_rdata",     bus_if.rdata,    16'hBEEF);
        check("rd_strb_off",  strobes_now(),   0);
        check("rd_gnt_done",  bus_if.gnt,      3'b010);
        cyc();
        check("rd_idle_gnt",  bus_if.gnt,      0);
        check("rd_idle_ack",  bus_if.ack,      0);
        check("rd_addr_hold", bus_if.bus_addr, 16'h0123);
        din_force_en = 1'b0;
        clear_log();

        // VRAM write by master 2.
        post(2, 1, 16'h6123, 1'b1, 16'h1234);
        cyc();
        check("wr_gnt",     bus_if.gnt,       3'b100);
        check("wr_vram_we", strobes_now(),    5'b00010);
        check("wr_wdata",   bus_if.bus_wdata, 16'h1234);
        drain("wr", 20);
        clear_log();

        // Contention: two rounds of 1+2, then GPU joins.
        post(1, 1, 16'h0100, 1'b0, 16'h0);
        post(2, 1, 16'h0200, 1'b0, 16'h0);
        drain("cont1", 40);
        post(1, 1, 16'h0100, 1'b0, 16'h0);
        post(2, 1, 16'h0200, 1'b0, 16'h0);
        drain("cont2", 40);
        post(0, 1, 16'h0300, 1'b0, 16'h0);
        post(1, 1, 16'h0100, 1'b0, 16'h0);
        post(2, 1, 16'h0200, 1'b0, 16'h0);
        drain("cont3", 60);
        exp_q = '{1, 2, 1, 2, 0, 1, 2};
        check_order("cont");
        clear_log();

        // Burst limit: master 1 wants 9 accesses, master 2 joins mid-burst.
        post(1, 9, 16'h0010, 1'b0, 16'h0);
        cyc();
        cyc();
        post(2, 1, 16'h0020, 1'b0, 16'h0);
        drain("burst", 200);
        exp_q = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1};
        check_order("burst");
        if (ack_at.size() >= 9) begin
            check("burst_rate",  ack_at[1] - ack_at[0], 2);
            check("burst_rearb", ack_at[8] - ack_at[7], 3);
        end
        clear_log();

        // GPU preempts master 2's burst at the next DONE.
        post(2, 4, 16'h0040, 1'b0, 16'h0);
        cyc();
        cyc();
        cyc();
        post(0, 1, 16'h0050, 1'b0, 16'h0);
        cyc();
        check("pre_ack2",    bus_if.ack, 3'b100);
        cyc();
        check("pre_gnt_off", bus_if.gnt, 0);
        cyc();
        check("pre_gnt_gpu", bus_if.gnt, 3'b001);
        drain("pre", 100);
        exp_q = '{2, 2, 0, 2, 2};
        check_order("pre");
        clear_log();

        // Protection: IROM write, unmapped read, then a legal IROM read.
        check("err_before", bus_if.err, 0);
        post(1, 1, 16'h8010, 1'b1, 16'hDEAD);
        cyc();
        check("prot_gnt",    bus_if.gnt,    3'b010);
        check("prot_strobe", strobes_now(), 0);
        cyc();
        check("prot_ack",    bus_if.ack,    3'b010);
        check("prot_err",    bus_if.err,    1);
        drain("prot", 20);
        cyc();
        cyc();
        check("prot_err_sticky", bus_if.err, 1);
        post(1, 1, 16'hC000, 1'b0, 16'h0);
        cyc();
        check("unmap_strobe", strobes_now(), 0);
        cyc();
        check("unmap_ack",    bus_if.ack,    3'b010);
        check("unmap_rdata",  bus_if.rdata,  0);
        drain("unmap", 20);
        post(1, 1, 16'h8004, 1'b0, 16'h0);
        cyc();
        check("irom_re",      strobes_now(), 5'b00001);
        cyc();
        check("irom_rdata",   bus_if.rdata,  16'h25A1);
        drain("irom", 20);
        clear_log();

        // Reset during ACCESS abandons the access.
        post(2, 1, 16'h0100, 1'b0, 16'h7777);
        cyc();
        check("rst_mid_pre", strobes_now(), 5'b10000);
        reset = 1'b1;
        cyc();
        check("rst_mid_gnt",    bus_if.gnt,       0);
        check("rst_mid_ack",    bus_if.ack,       0);
        check("rst_mid_strobe", strobes_now(),    0);
        check("rst_mid_err",    bus_if.err,       0);
        check("rst_mid_addr",   bus_if.bus_addr,  0);
        check("rst_mid_wdata",  bus_if.bus_wdata, 0);
        check("rst_mid_rdata",  bus_if.rdata,     0);
        reset = 1'b0;
        cyc();
        check("rst_mid_no_ack", bus_if.ack, 0);
        check("rst_mid_idle",   bus_if.gnt, 0);
        clear_log();
        post(1, 1, 16'h0300, 1'b0, 16'h0);
        post(2, 1, 16'h0400, 1'b0, 16'h0);
        drain("post_rst", 40);
        exp_q = '{1, 2};
        check_order("post_rst");

        check("onehot_viol", onehot_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
